// File: rtl/bce_param_accum_if.sv
// Beat/result bus of the bit-column engine: sign load, column beats in, group sums out.
interface bce_param_accum_if #(
  parameter int LANES   = 8,
  parameter int ACT_W   = 8,
  parameter int SHIFT_W = 3,
  parameter int ACC_W   = 24
);
  logic                     clr;
  logic                     sign_valid;
  logic [LANES-1:0]         sign_bits;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*ACT_W-1:0]   in_act;
  logic [LANES-1:0]         in_wcol;
  logic [SHIFT_W-1:0]       in_shift;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_W-1:0]         out_result;
  logic                     out_sat;
  logic                     busy;

  modport master (
    output clr, sign_valid, sign_bits, in_valid, in_act, in_wcol, in_shift, in_last, out_ready,
    input  in_ready, out_valid, out_result, out_sat, busy
  );

  modport slave (
    input  clr, sign_valid, sign_bits, in_valid, in_act, in_wcol, in_shift, in_last, out_ready,
    output in_ready, out_valid, out_result, out_sat, busy
  );
endinterface

// File: rtl/bce_param_accum.sv
// Bit-column engine: signed per-lane select of activations, adder tree, shift by
// bit significance, saturating accumulation over a group of beats.
module bce_param_accum #(
  parameter int LANES      = 8,
  parameter int ACT_W      = 8,
  parameter int SIGNED_ACT = 1,
  parameter int SHIFT_W    = 3,
  parameter int ACC_W      = 24
) (
  input  logic             clk,
  input  logic             rst,
  bce_param_accum_if.slave bus
);
  localparam int STAGES = 2;
  localparam int LG     = $clog2(LANES);
  localparam int TREE_W = ACT_W + 1 + LG;
  localparam int TERM_W = TREE_W + (1 << SHIFT_W) - 1;
  // Sum is wide enough that neither the shifted term nor acc+term can wrap before clamping.
  localparam int SUM_W  = ((ACC_W > TERM_W) ? ACC_W : TERM_W) + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef struct packed {
    logic [LANES-1:0][ACT_W-1:0] act;
    logic [LANES-1:0]            wcol;
    logic [LANES-1:0]            sign;
    logic [SHIFT_W-1:0]          shift;
    logic                        last;
  } s1_t;

  typedef struct packed {
    logic [TERM_W-1:0] term;
    logic              last;
  } s2_t;

  logic [LANES-1:0]          sign_q;
  logic [LANES-1:0]          sign_eff;
  s1_t                       s1_q, s1_d;
  s2_t                       s2_q, s2_d;
  logic [STAGES:1]           vld_q;
  logic [STAGES:0]           vld_pipe;
  logic                      in_ready;
  logic                      accept;
  logic [LANES-1:0][ACT_W:0] prod;
  logic signed [TREE_W-1:0]  tree;
  logic signed [TERM_W-1:0]  term;
  logic signed [SUM_W-1:0]   sum;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   res_q;
  logic                      sat_hit;
  logic                      sat_q;
  logic                      osat_q;
  logic                      ov_q;

  // One bubble per group: a last beat in flight blocks intake until its result is taken.
  assign in_ready = !ov_q && !(vld_q[1] && s1_q.last) && !(vld_q[2] && s2_q.last);
  assign accept   = bus.in_valid && in_ready;
  assign vld_pipe = {vld_q, accept};
  assign sign_eff = bus.sign_valid ? bus.sign_bits : sign_q;

  always_comb begin
    s1_d       = '0;
    s1_d.act   = bus.in_act;
    s1_d.wcol  = bus.in_wcol;
    s1_d.sign  = sign_eff;
    s1_d.shift = bus.in_shift;
    s1_d.last  = bus.in_last;
  end

  // Products are ACT_W+1 bits so negating the most negative activation stays exact.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [ACT_W:0] ext;
    assign ext     = $signed({(SIGNED_ACT != 0) & s1_q.act[g][ACT_W-1], s1_q.act[g]});
    assign prod[g] = !s1_q.wcol[g] ? '0 : (s1_q.sign[g] ? -ext : ext);
  end

  always_comb begin
    tree = '0;
    for (int i = 0; i < LANES; i++) tree = tree + TREE_W'($signed(prod[i]));
  end

  assign term = TERM_W'(tree) <<< s1_q.shift;

  always_comb begin
    s2_d      = '0;
    s2_d.term = term;
    s2_d.last = s1_q.last;
  end

  always_comb begin
    sum     = SUM_W'(acc_q) + SUM_W'($signed(s2_q.term));
    acc_d   = ACC_W'(sum);
    sat_hit = 1'b0;
    if (sum > SUM_W'(ACC_MAX)) begin
      acc_d   = ACC_MAX;
      sat_hit = 1'b1;
    end else if (sum < SUM_W'(ACC_MIN)) begin
      acc_d   = ACC_MIN;
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      vld_q  <= '0;
      acc_q  <= '0;
      sat_q  <= 1'b0;
      res_q  <= '0;
      osat_q <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      if (bus.sign_valid) sign_q <= bus.sign_bits;
      if (accept)         s1_q   <= s1_d;
      if (vld_pipe[1])    s2_q   <= s2_d;
      if (bus.clr) begin
        vld_q <= '0;
        acc_q <= '0;
        sat_q <= 1'b0;
        ov_q  <= 1'b0;
      end else begin
        vld_q <= vld_pipe[STAGES-1:0];
        if (ov_q && bus.out_ready) ov_q <= 1'b0;
        if (vld_pipe[STAGES]) begin
          if (s2_q.last) begin
            res_q  <= acc_d;
            osat_q <= sat_q | sat_hit;
            ov_q   <= 1'b1;
            acc_q  <= '0;
            sat_q  <= 1'b0;
          end else begin
            acc_q  <= acc_d;
            sat_q  <= sat_q | sat_hit;
          end
        end
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = ov_q;
  assign bus.out_result = res_q;
  assign bus.out_sat    = osat_q;
  assign bus.busy       = (|vld_q) || (acc_q != '0) || sat_q;
endmodule

// File: tb/tb_bce_param_accum.sv
// Directed bench: one default-width engine and one ACC_W=16 engine for saturation.
module tb_bce_param_accum;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        clr = 1'b0, sign_valid = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0]  sign_bits = '0, in_wcol = '0;
  logic [63:0] in_act = '0;
  logic [2:0]  in_shift = '0;

  bce_param_accum_if #(.LANES(8), .ACT_W(8), .SHIFT_W(3), .ACC_W(24)) bus8 ();
  bce_param_accum_if #(.LANES(8), .ACT_W(8), .SHIFT_W(3), .ACC_W(16)) bus16 ();

  assign bus8.clr         = clr;
  assign bus8.sign_valid  = sign_valid;
  assign bus8.sign_bits   = sign_bits;
  assign bus8.in_valid    = in_valid & ~sel;
  assign bus8.in_act      = in_act;
  assign bus8.in_wcol     = in_wcol;
  assign bus8.in_shift    = in_shift;
  assign bus8.in_last     = in_last;
  assign bus8.out_ready   = out_ready;
  assign bus16.clr        = clr;
  assign bus16.sign_valid = sign_valid;
  assign bus16.sign_bits  = sign_bits;
  assign bus16.in_valid   = in_valid & sel;
  assign bus16.in_act     = in_act;
  assign bus16.in_wcol    = in_wcol;
  assign bus16.in_shift   = in_shift;
  assign bus16.in_last    = in_last;
  assign bus16.out_ready  = out_ready;

  bce_param_accum #(.LANES(8), .ACT_W(8), .SIGNED_ACT(1), .SHIFT_W(3), .ACC_W(24)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8));
  bce_param_accum #(.LANES(8), .ACT_W(8), .SIGNED_ACT(1), .SHIFT_W(3), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16));

  logic               rdy, ov, sat, busy;
  logic signed [23:0] res;
  assign rdy  = sel ? bus16.in_ready  : bus8.in_ready;
  assign ov   = sel ? bus16.out_valid : bus8.out_valid;
  assign sat  = sel ? bus16.out_sat   : bus8.out_sat;
  assign busy = sel ? bus16.busy      : bus8.busy;
  assign res  = sel ? {{8{bus16.out_result[15]}}, bus16.out_result} : bus8.out_result;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [63:0] fill(input logic [7:0] a);
    return {8{a}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] a, input logic [7:0] w, input logic [2:0] s, input logic l);
    int n = 0;
    in_act = a; in_wcol = w; in_shift = s; in_last = l; in_valid = 1'b1;
    while (!rdy && n < 50) begin
      step();
      n++;
    end
    chk("beat_ready_wait", rdy, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic result(input string tag, input logic signed [23:0] exp, input logic esat);
    step();
    step();
    chk({tag, "_valid"}, ov, 1'b1);
    chk({tag, "_result"}, res, exp);
    chk({tag, "_sat"}, sat, esat);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    chk({tag, "_drain"}, ov, 1'b0);
  endtask

  task automatic load_sign(input logic [7:0] v);
    sign_valid = 1'b1; sign_bits = v;
    step();
    sign_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #8;
    chk("rst_in_ready", rdy, 1'b1);
    chk("rst_out_valid", ov, 1'b0);
    chk("rst_result", res, 0);
    chk("rst_sat", sat, 1'b0);
    chk("rst_busy", busy, 1'b0);
    #4 rst = 1'b0;
    step();

    // three beats, shifts 0/1/2: 36 + 72 + 144
    beat(64'h0807060504030201, 8'hFF, 3'd0, 1'b0);
    beat(64'h0807060504030201, 8'hFF, 3'd1, 1'b0);
    beat(64'h0807060504030201, 8'hFF, 3'd2, 1'b1);
    chk("t1_bubble_ready", rdy, 1'b0);
    chk("t1_not_early", ov, 1'b0);
    result("t1", 24'sd252, 1'b0);
    drain("t1");

    // -(-128) is exact: mixed signs cancel, then half the column gives 512<<7
    load_sign(8'h0F);
    beat(fill(8'h80), 8'hFF, 3'd7, 1'b1);
    result("t2a", 24'sd0, 1'b0);
    drain("t2a");
    beat(fill(8'h80), 8'h0F, 3'd7, 1'b1);
    result("t2b", 24'sd65536, 1'b0);
    drain("t2b");

    // 16-bit accumulator saturates, next group starts clean
    load_sign(8'h00);
    sel = 1'b1;
    for (int i = 0; i < 4; i++) beat(fill(8'd127), 8'hFF, 3'd7, i == 3);
    result("t3_sat", 24'sd32767, 1'b1);
    drain("t3_sat");
    beat(fill(8'd1), 8'h01, 3'd0, 1'b1);
    result("t3_next", 24'sd1, 1'b0);
    drain("t3_next");
    sel = 1'b0;

    // backpressure: result held, next beat waits and is not lost
    beat(64'h0807060504030201, 8'hFF, 3'd0, 1'b1);
    out_ready = 1'b0;
    result("t4_first", 24'sd36, 1'b0);
    in_act = fill(8'd2); in_wcol = 8'hFF; in_shift = 3'd1; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", ov, 1'b1);
      chk("t4_hold_result", res, 24'sd36);
      chk("t4_hold_ready", rdy, 1'b0);
    end
    out_ready = 1'b1;
    step();
    chk("t4_release_valid", ov, 1'b0);
    chk("t4_release_ready", rdy, 1'b1);
    step();
    in_valid = 1'b0;
    result("t4_second", 24'sd32, 1'b0);
    drain("t4_second");

    // sign load bypasses into the beat accepted the same cycle
    sign_valid = 1'b1; sign_bits = 8'hFF;
    beat(fill(8'd3), 8'hFF, 3'd0, 1'b1);
    sign_valid = 1'b0;
    result("t5_bypass", -24'sd24, 1'b0);
    drain("t5_bypass");

    // clear mid-group, including a last beat offered during the clear cycle
    load_sign(8'h00);
    beat(fill(8'd5), 8'hFF, 3'd0, 1'b0);
    beat(fill(8'd5), 8'hFF, 3'd0, 1'b0);
    chk("t6_busy_before", busy, 1'b1);
    clr = 1'b1;
    in_act = fill(8'd9); in_wcol = 8'hFF; in_shift = 3'd0; in_last = 1'b1; in_valid = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0;
    chk("t6_busy_after", busy, 1'b0);
    step();
    step();
    chk("t6_no_result", ov, 1'b0);
    beat(fill(8'd1), 8'h01, 3'd0, 1'b1);
    result("t6_after_clr", 24'sd1, 1'b0);
    drain("t6_after_clr");

    // async reset mid-group
    beat(fill(8'd7), 8'hFF, 3'd0, 1'b0);
    beat(fill(8'd7), 8'hFF, 3'd0, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("t7_rst_valid", ov, 1'b0);
    chk("t7_rst_result", res, 0);
    chk("t7_rst_sat", sat, 1'b0);
    chk("t7_rst_ready", rdy, 1'b1);
    chk("t7_rst_busy", busy, 1'b0);
    #1 rst = 1'b0;
    beat(fill(8'd1), 8'h01, 3'd0, 1'b1);
    result("t7_after_rst", 24'sd1, 1'b0);
    drain("t7_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
